// File: rtl/cam_pkg.sv
// Shared definitions for the OV7670 emulator: RGB565 test colours,
// pattern_sel encodings and the frame-timing FSM state codes.
package cam_pkg;

  localparam logic [15:0] RED_565   = 16'hF800;
  localparam logic [15:0] GREEN_565 = 16'h07E0;
  localparam logic [15:0] BLUE_565  = 16'h001F;

  typedef enum logic [1:0] {
    PAT_RED      = 2'd0,
    PAT_GREEN    = 2'd1,
    PAT_BLUE     = 2'd2,
    PAT_GRADIENT = 2'd3
  } pattern_e;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_VSYNC  = 3'd1;
  localparam state_t ST_VBACK  = 3'd2;
  localparam state_t ST_ACTIVE = 3'd3;
  localparam state_t ST_HBLANK = 3'd4;

  function automatic logic [15:0] gradient565(input logic [4:0] x, input logic [5:0] y);
    return {x, y, 5'b00000};
  endfunction

endpackage

// File: rtl/ov7670_emu_if.sv
// OV7670 parallel pixel bus; the emulator is the master (camera end),
// a capture block such as cam_read is the slave.
interface ov7670_emu_if;

  logic       CAM_pclk;
  logic       CAM_vsync;
  logic       CAM_href;
  logic [7:0] CAM_px_data;

  modport master (output CAM_pclk, output CAM_vsync, output CAM_href, output CAM_px_data);
  modport slave  (input  CAM_pclk, input  CAM_vsync, input  CAM_href, input  CAM_px_data);

endinterface

// File: rtl/ov7670_pattern_gen.sv
// Combinational RGB565 pixel value for the selected test pattern at (x, y).
module ov7670_pattern_gen
  import cam_pkg::*;
#(
  parameter int XW = 8,
  parameter int YW = 7
) (
  input  logic [1:0]    i_pattern,
  input  logic [XW-1:0] i_x,
  input  logic [YW-1:0] i_y,
  output logic [15:0]   o_pixel
);

  logic [4:0] w_xLow;
  logic [5:0] w_yLow;

  // The gradient only uses the low coordinate bits, so narrower or wider counters both fit.
  assign w_xLow = 5'(i_x);
  assign w_yLow = 6'(i_y);

  always_comb begin
    o_pixel = 16'h0000;
    case (i_pattern)
      PAT_RED:      o_pixel = RED_565;
      PAT_GREEN:    o_pixel = GREEN_565;
      PAT_BLUE:     o_pixel = BLUE_565;
      PAT_GRADIENT: o_pixel = gradient565(w_xLow, w_yLow);
      default:      o_pixel = 16'h0000;
    endcase
  end

endmodule

// File: rtl/ov7670_emu.sv
// OV7670 sensor emulator: streams RGB565 test frames on the parallel bus,
// with every state change on the CAM_pclk falling edge so data is stable at its rise.
module ov7670_emu
  import cam_pkg::*;
#(
  parameter int CAM_SCREEN_X = 160,
  parameter int CAM_SCREEN_Y = 120,
  parameter int VSYNC_PCLK   = 8,
  parameter int VBACK_PCLK   = 4,
  parameter int HBLANK_PCLK  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [1:0]       pattern_sel,
  ov7670_emu_if.master     cam,
  output logic             frame_done
);

  localparam int XW    = $clog2(CAM_SCREEN_X);
  localparam int YW    = $clog2(CAM_SCREEN_Y);
  localparam int BMAX0 = (VSYNC_PCLK > VBACK_PCLK) ? VSYNC_PCLK : VBACK_PCLK;
  localparam int BMAX  = (BMAX0 > HBLANK_PCLK) ? BMAX0 : HBLANK_PCLK;
  localparam int CW    = $clog2(BMAX + 1);

  logic          r_pclk;
  logic          r_frameDone;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic          r_phase;
  logic [1:0]    r_pattern;

  logic          w_tick;
  logic [15:0]   w_pixel;

  assign w_tick = r_pclk;

  ov7670_pattern_gen #(.XW(XW), .YW(YW)) u_patternGen (
    .i_pattern (r_pattern),
    .i_x       (r_x),
    .i_y       (r_y),
    .o_pixel   (w_pixel)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pclk      <= 1'b0;
      r_frameDone <= 1'b0;
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_phase     <= 1'b0;
      r_pattern   <= '0;
    end else begin
      r_pclk      <= ~r_pclk;
      r_frameDone <= 1'b0;
      if (w_tick) begin
        case (r_state)
          ST_IDLE: begin
            if (enable) begin
              r_pattern <= pattern_sel;
              r_cnt     <= '0;
              r_state   <= ST_VSYNC;
            end
          end
          ST_VSYNC: begin
            if (r_cnt == CW'(VSYNC_PCLK - 1)) begin
              r_cnt   <= '0;
              r_state <= ST_VBACK;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          ST_VBACK: begin
            if (r_cnt == CW'(VBACK_PCLK - 1)) begin
              r_cnt   <= '0;
              r_x     <= '0;
              r_y     <= '0;
              r_phase <= 1'b0;
              r_state <= ST_ACTIVE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          ST_ACTIVE: begin
            r_phase <= ~r_phase;
            if (r_phase) begin
              if (r_x == XW'(CAM_SCREEN_X - 1)) begin
                r_x     <= '0;
                r_cnt   <= '0;
                r_state <= ST_HBLANK;
              end else begin
                r_x <= r_x + 1'b1;
              end
            end
          end
          ST_HBLANK: begin
            if (r_cnt == CW'(HBLANK_PCLK - 1)) begin
              r_cnt <= '0;
              if (r_y < YW'(CAM_SCREEN_Y - 1)) begin
                r_y     <= r_y + 1'b1;
                r_state <= ST_ACTIVE;
              end else begin
                // Last line's blanking ends the frame; enable decides whether another follows.
                r_y         <= '0;
                r_frameDone <= 1'b1;
                if (enable) begin
                  r_pattern <= pattern_sel;
                  r_state   <= ST_VSYNC;
                end else begin
                  r_state <= ST_IDLE;
                end
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign cam.CAM_pclk    = r_pclk;
  assign cam.CAM_vsync   = (r_state == ST_VSYNC);
  assign cam.CAM_href    = (r_state == ST_ACTIVE);
  assign cam.CAM_px_data = (r_state == ST_ACTIVE) ? (r_phase ? w_pixel[7:0] : w_pixel[15:8]) : 8'h00;
  assign frame_done      = r_frameDone;

endmodule
